// File: rtl/regfile_wb.sv
// 32-entry MIPS32 general-purpose register file. It has one write-back port and two
// decode read ports, plus optional same-cycle write-to-read forwarding.
module regfile_wb #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter bit          READ_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Flat flop array so that reset can clear every entry; entry 0 is never written
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_wr_en;
  logic              w_hit1;
  logic              w_hit2;

  assign w_wr_en = we && (waddr != '0);
  assign w_hit1  = READ_BYPASS && we && (raddr1 == waddr);
  assign w_hit2  = READ_BYPASS && we && (raddr2 == waddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Read priority: reset, enable, r0, bypass, stored value
  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (w_hit1) begin
        rdata1 = wdata;
      end else begin
        rdata1 = r_regs[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (w_hit2) begin
        rdata2 = wdata;
      end else begin
        rdata2 = r_regs[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb. One instance has the write-to-read bypass on and the
// other has it off; both are driven from the same inputs.
module tb_regfile_wb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1_a;
  logic [DATA_W-1:0] rdata2_a;
  logic [DATA_W-1:0] rdata1_b;
  logic [DATA_W-1:0] rdata2_b;

  int n_pass;
  int n_total;

  regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_a),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_a)
  );

  regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_b),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    tick();
    check("rst_init_p1", rdata1_a, 32'h0);
    check("rst_init_p2", rdata2_a, 32'h0);

    // Reset clear
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    #1;
    check("r5_written", rdata1_a, 32'hDEADBEEF);
    check("r5_written_nb", rdata1_b, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("rst_comb_p1", rdata1_a, 32'h0);
    check("rst_comb_p2", rdata2_a, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("r5_cleared", rdata1_a, 32'h0);
    check("r5_cleared_nb", rdata1_b, 32'h0);

    // Basic write/read
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
    tick();
    waddr = 5'd31; wdata = 32'hFFFFFFFF;
    tick();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd31;
    #1;
    check("basic_r3", rdata1_a, 32'h12345678);
    check("basic_r31", rdata2_a, 32'hFFFFFFFF);
    check("basic_r3_nb", rdata1_b, 32'h12345678);
    check("basic_r31_nb", rdata2_b, 32'hFFFFFFFF);

    // Register zero
    we = 1'b1; waddr = 5'd0; wdata = 32'hAAAA5555; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("r0_same_cyc", rdata1_a, 32'h0);
    check("r0_same_cyc_p2", rdata2_a, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("r0_next_cyc", rdata1_a, 32'h0);
    check("r0_next_cyc_nb", rdata1_b, 32'h0);

    // Bypass on and off
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    tick();
    wdata = 32'h22222222; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("byp_p1", rdata1_a, 32'h22222222);
    check("byp_p2", rdata2_a, 32'h22222222);
    check("nobyp_p1", rdata1_b, 32'h11111111);
    check("nobyp_p2", rdata2_b, 32'h11111111);
    tick();
    we = 1'b0;
    #1;
    check("byp_next_p1", rdata1_a, 32'h22222222);
    check("byp_next_p2", rdata2_a, 32'h22222222);
    check("nobyp_next_p1", rdata1_b, 32'h22222222);
    check("nobyp_next_p2", rdata2_b, 32'h22222222);

    // Read enable gating; a disabled port also ignores a bypass hit
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000ABCD;
    tick();
    we = 1'b0; re1 = 1'b0; raddr1 = 5'd9;
    #1;
    check("re1_off", rdata1_a, 32'h0);
    check("re1_off_nb", rdata1_b, 32'h0);
    re1 = 1'b1;
    #1;
    check("re1_on", rdata1_a, 32'h0000ABCD);
    re2 = 1'b0; raddr2 = 5'd9; we = 1'b1; wdata = 32'h5A5A5A5A;
    #1;
    check("re2_off_byp", rdata2_a, 32'h0);
    check("re1_on_byp", rdata1_a, 32'h5A5A5A5A);
    we = 1'b0; re2 = 1'b1;
    #1;

    // Write/reset collision
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h55555555; raddr2 = 5'd4;
    #1;
    check("coll_rst_byp", rdata2_a, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0; raddr1 = 5'd4;
    #1;
    check("coll_r4", rdata1_a, 32'h0);
    check("coll_r4_nb", rdata1_b, 32'h0);
    raddr1 = 5'd3;
    #1;
    check("r3_cleared", rdata1_a, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
